// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame TX arbiter.
package frame_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEF_IFG = 12;
    localparam int DEF_TMO = 64;

    // Index width that never collapses to zero for tiny channel counts.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_tx_arbiter_rr_arbiter.sv
// Channel selector: round-robin from ptr_i, or fixed priority (ch0 highest)
// when FRAME_TX_ARB_STRICT_PRIO_EN is defined.
module rr_arbiter
    import frame_tx_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = clog2w(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o
);

    logic found;

`ifdef FRAME_TX_ARB_STRICT_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = IW'((int'(ptr_i) + k) % NCH);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/frame_tx_arbiter.sv
// Multi-channel frame TX arbiter with inter-frame gap and stall/link aborts.
// Build option: FRAME_TX_ARB_STRICT_PRIO_EN selects fixed-priority arbitration.
module frame_tx_arbiter
    import frame_tx_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IFG = DEF_IFG,
    parameter int TMO = DEF_TMO
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     LinkUp,
    input  logic [NCH-1:0]           ReqIn,
    input  logic [NCH-1:0]           ValIn,
    input  logic [NCH-1:0]           SoFIn,
    input  logic [NCH-1:0]           EoFIn,
    input  logic [NCH*8-1:0]         DataIn,
    output logic [NCH-1:0]           ReqConfirm,
    output logic                     ValOut,
    output logic                     SoFOut,
    output logic                     EoFOut,
    output logic [7:0]               DataOut,
    output logic                     ErrOut,
    output logic [clog2w(NCH)-1:0]   ChanOut,
    output logic                     Busy
);

    localparam int IW = clog2w(NCH);
    localparam int TW = $clog2(TMO + 1);

    state_t         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [IW-1:0]  chan_q, chan_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     gap_q, gap_d;
    logic           val_q, val_d, sof_q, sof_d, eof_q, eof_d, err_q, err_d;
    logic [7:0]     data_q, data_d;

    logic [NCH-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic           g_val, g_sof, g_eof;
    logic [7:0]     g_data;
    logic           go_gap, abort;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .req_i (ReqIn),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        g_val  = 1'b0;
        g_sof  = 1'b0;
        g_eof  = 1'b0;
        g_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chan_q == IW'(i)) begin
                g_val  = ValIn[i];
                g_sof  = SoFIn[i];
                g_eof  = EoFIn[i];
                g_data = DataIn[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        val_d   = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        data_d  = '0;
        go_gap  = 1'b0;
        abort   = 1'b0;

        case (state_q)
            IDLE: begin
                if (LinkUp && (|ReqIn)) begin
                    state_d = GRANT;
                    gnt_d   = arb_gnt;
                    chan_d  = arb_idx;
                    ptr_d   = (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + IW'(1);
                    tmo_d   = TW'(TMO);
                end
            end
            GRANT: begin
                if (!LinkUp) begin
                    go_gap = 1'b1;
                end else if (g_val && g_sof) begin
                    state_d = XFER;
                    val_d   = 1'b1;
                    sof_d   = 1'b1;
                    eof_d   = g_eof;
                    data_d  = g_data;
                    tmo_d   = TW'(TMO);
                    go_gap  = g_eof;
                end else if (g_val) begin
                    tmo_d = TW'(TMO);
                end else if (tmo_q == TW'(1)) begin
                    go_gap = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            XFER: begin
                // A valid EoF byte reloads the timer, so it always wins over expiry.
                if (!LinkUp || (g_val && g_sof)) begin
                    abort  = 1'b1;
                    go_gap = 1'b1;
                end else if (g_val) begin
                    val_d  = 1'b1;
                    eof_d  = g_eof;
                    data_d = g_data;
                    tmo_d  = TW'(TMO);
                    go_gap = g_eof;
                end else if (tmo_q == TW'(1)) begin
                    abort  = 1'b1;
                    go_gap = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            GAP: begin
                // First GAP cycle carries the closing EoF; IFG silent cycles follow.
                if (gap_q == 8'd0) state_d = IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            val_d  = 1'b1;
            eof_d  = 1'b1;
            err_d  = 1'b1;
            data_d = 8'h00;
        end
        if (go_gap) begin
            state_d = GAP;
            gnt_d   = '0;
            chan_d  = '0;
            gap_d   = 8'(IFG);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            val_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            val_q   <= val_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign ReqConfirm = gnt_q;
    assign ChanOut    = chan_q;
    assign ValOut     = val_q;
    assign SoFOut     = sof_q;
    assign EoFOut     = eof_q;
    assign ErrOut     = err_q;
    assign DataOut    = data_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: doc/frame_tx_arbiter.md
FRAME_TX_ARBITER -- requirements
Module: frame_tx_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of TX source channels (2..8).
REQ-002 SHALL have parameter IFG, default 12, idle cycles inserted between frames (1..255).
REQ-003 SHALL have parameter TMO, default 64, max cycles without ValIn from granted channel before abort (>=4).
REQ-004 SHALL have ports:
- Clk  in  1  single clock.
- Rst  in  1  synchronous, active-high reset.
- LinkUp  in  1  PHY link status.
- ReqIn  in  NCH  per-channel request to send one frame.
- ValIn  in  NCH  per-channel byte valid.
- SoFIn  in  NCH  per-channel first-byte flag.
- EoFIn  in  NCH  per-channel last-byte flag.
- DataIn  in  NCH*8  per-channel byte; channel i at [8i+7:8i].
- ReqConfirm  out  NCH  one-hot grant.
- ValOut  out  1  output byte valid.
- SoFOut  out  1  output first-byte flag.
- EoFOut  out  1  output last-byte flag.
- DataOut  out  8  output byte.
- ErrOut  out  1  frame aborted; qualifies EoFOut.
- ChanOut  out  clog2(NCH)  index of granted channel.
- Busy  out  1  state is not IDLE.

Function
REQ-005 SHALL implement states IDLE, GRANT, XFER, GAP.
REQ-006 IDLE: when LinkUp=1 and any ReqIn=1, SHALL select one channel and enter GRANT next cycle; when LinkUp=0, SHALL make no grant.
REQ-007 Selection SHALL be round-robin: search starts at the channel after the last granted one; after reset the search starts at channel 0.
REQ-008 ReqConfirm SHALL be asserted one-hot from entry to GRANT until the cycle after the granted EoF is forwarded, and ChanOut SHALL hold the granted index for the same interval.
REQ-009 GRANT: on ValIn&SoFIn of the granted channel, SHALL enter XFER; ValIn without SoFIn SHALL be dropped.
REQ-010 XFER: every ValIn byte of the granted channel SHALL appear on DataOut/ValOut/SoFOut/EoFOut exactly 1 cycle later (registered); inputs of non-granted channels SHALL be ignored.
REQ-011 XFER: on forwarded EoFIn, SHALL enter GAP and deassert ReqConfirm.
REQ-012 GAP: SHALL hold ValOut=0 for exactly IFG cycles, then enter IDLE; requests are evaluated only in IDLE.
REQ-013 Timeout: in GRANT or XFER, if no granted ValIn occurs for TMO consecutive cycles, SHALL enter GAP. If that happens in XFER, SHALL emit one cycle ValOut=1, EoFOut=1, ErrOut=1, DataOut=0x00.
REQ-014 LinkUp falling in XFER SHALL abort the frame the same way (ErrOut pulse) next cycle; in GRANT it SHALL enter GAP silently.
REQ-015 A second SoFIn in XFER SHALL abort the current frame with ErrOut and enter GAP.
REQ-016 Withdrawal of ReqIn after grant SHALL NOT affect the grant.
REQ-017 Simultaneous EoFIn and timeout expiry SHALL count as normal completion (ErrOut=0).
REQ-018 ErrOut SHALL be asserted only together with EoFOut.

Reset
REQ-019 While Rst=1, SHALL force state IDLE, all outputs 0 and the round-robin pointer to channel 0; the timeout and gap counters SHALL be cleared.
REQ-020 Rst asserted mid-frame SHALL truncate output without an ErrOut pulse.

Configuration
REQ-021 With FRAME_TX_ARB_STRICT_PRIO_EN defined, selection SHALL be fixed priority with channel 0 highest and the pointer unused; without the macro, selection SHALL be round-robin per REQ-007.

Structure
REQ-022 Package frame_tx_pkg SHALL hold the state enum, the default IFG and TMO constants, and the clog2 width function.
REQ-023 Channel selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot grant and index), which also contains the strict-priority variant.

Verification
REQ-024 Ch1 requests and sends a 64-byte frame -> ReqConfirm=0010, ChanOut=1, 64 bytes out with 1-cycle latency, then 12 idle cycles.
REQ-025 Ch0 and ch2 request continuously, 3 frames each -> grant order 0,2,0,2,0,2 (with STRICT_PRIO_EN: 0,0,0,2,2,2).
REQ-026 Ch3 granted, sends 10 bytes, then stalls for 64 cycles -> EoFOut=1, ErrOut=1, DataOut=0x00 after the 64-cycle stall, then GAP.
REQ-027 LinkUp drops at byte 5 -> abort pulse next cycle; with LinkUp=0 and ReqIn=1111 -> no grant.
REQ-028 Rst at byte 20 -> all outputs 0 next cycle; after Rst release with ReqIn=0110 -> first grant to ch1.
REQ-029 Ch2 sends bytes while ch0 is granted -> none of ch2's bytes appear on the output.
